// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and request typedef for the SRAM arbitration slice.
package sram_ctrl_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int DATA_W_DEF  = 128;
    localparam int NUM_REQ_DEF = 2;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } sram_req_t;

    // Pointer width that stays legal for a single requester.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot selector: first eligible index at or after the pointer,
// wrapping to the indices below it.
module rr_arbiter
    import sram_ctrl_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && (k >= int'(i_ptr)) && i_elig[k]) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (!w_found && (k < int'(i_ptr)) && i_elig[k]) begin
                o_grant[k] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Multi-requester arbiter for a single-port SRAM: round-robin grant, one
// outstanding read per requester held in a per-requester response slot.
module sram_arb
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NUM_REQ = NUM_REQ_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    input  logic [NUM_REQ-1:0]               rsp_ready,
    output logic [NUM_REQ-1:0][DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]                sram_a,
    output logic                             sram_csb,
    output logic                             sram_web,
    output logic                             sram_oeb,
    output logic [DATA_W-1:0]                sram_i,
    input  logic [DATA_W-1:0]                sram_o
);

    localparam int PW = ptr_w(NUM_REQ);

    logic [NUM_REQ-1:0]             r_inflight;
    logic [NUM_REQ-1:0]             r_slot_v;
    logic [NUM_REQ-1:0][DATA_W-1:0] r_slot_d;
    logic [PW-1:0]                  r_ptr;
    logic [ADDR_W-1:0]              r_a;
    logic [DATA_W-1:0]              r_i;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_arb;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_drain;
    logic               w_any;
    logic               w_g_we;
    logic [ADDR_W-1:0]  w_g_addr;
    logic [DATA_W-1:0]  w_g_wdata;
    logic [PW-1:0]      w_gidx;
    logic [PW-1:0]      w_ptr_nxt;

    // A read may reissue in the same cycle its slot is being drained.
    assign w_drain = r_slot_v & rsp_ready;
    assign w_elig  = req_valid & (req_we | (~r_inflight & (~r_slot_v | rsp_ready)));

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_arb)
    );

    assign w_grant   = w_arb & {NUM_REQ{~rst}};
    assign w_any     = |w_grant;
    assign req_ready = w_grant;

    always_comb begin
        w_g_we    = 1'b0;
        w_g_addr  = '0;
        w_g_wdata = '0;
        w_gidx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_g_we    = req_we[k];
                w_g_addr  = req_addr[k];
                w_g_wdata = req_wdata[k];
                w_gidx    = PW'(k);
            end
        end
    end

    assign w_ptr_nxt = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;

    assign sram_csb = ~w_any;
    assign sram_web = w_any ? ~w_g_we : 1'b1;
    assign sram_a   = w_any ? w_g_addr : r_a;
    assign sram_i   = w_any ? w_g_wdata : r_i;
    assign sram_oeb = 1'b0;

    assign rsp_valid = r_slot_v;
    assign rsp_rdata = r_slot_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
            r_slot_v   <= '0;
            r_slot_d   <= '0;
            r_ptr      <= '0;
            r_a        <= '0;
            r_i        <= '0;
        end else begin
            if (w_any) begin
                r_a   <= w_g_addr;
                r_i   <= w_g_wdata;
                r_ptr <= w_ptr_nxt;
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                r_inflight[k] <= w_grant[k] & ~req_we[k];
                // SRAM output is valid the cycle after the read was accepted.
                if (r_inflight[k]) begin
                    r_slot_v[k] <= 1'b1;
                    r_slot_d[k] <= sram_o;
                end else if (w_drain[k]) begin
                    r_slot_v[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb with a behavioural single-port SRAM.
module tb_sram_arb;

    localparam int AW = 9;
    localparam int DW = 128;
    localparam int NR = 2;

    logic                  clk;
    logic                  rst;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [NR-1:0]         req_we;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][DW-1:0] req_wdata;
    logic [NR-1:0]         rsp_valid;
    logic [NR-1:0]         rsp_ready;
    logic [NR-1:0][DW-1:0] rsp_rdata;
    logic [AW-1:0]         sram_a;
    logic                  sram_csb;
    logic                  sram_web;
    logic                  sram_oeb;
    logic [DW-1:0]         sram_i;
    logic [DW-1:0]         sram_o;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    int nchk;
    int nerr;

    localparam logic [DW-1:0] D_A5  = {16{8'hA5}};
    localparam logic [DW-1:0] D_3C  = {16{8'h3C}};
    localparam logic [DW-1:0] D_11  = {16{8'h11}};
    localparam logic [DW-1:0] D_22  = {16{8'h22}};
    localparam logic [DW-1:0] D_R0  = {16{8'h10}};
    localparam logic [DW-1:0] D_R1  = {16{8'h20}};

    sram_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .sram_a    (sram_a),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_i    (sram_i),
        .sram_o    (sram_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) mem[sram_a] <= sram_i;
            else           r_q <= mem[sram_a];
        end
    end
    assign sram_o = r_q;

    task automatic idle_inputs();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
        nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rst_rsp_valid: got %b expected 00", rsp_valid); end
        nchk++; if (rsp_rdata !== '0) begin nerr++; $display("FAIL rst_rdata: got %h expected 0", rsp_rdata); end
        nchk++; if (sram_csb !== 1'b1 || sram_web !== 1'b1) begin nerr++; $display("FAIL rst_csb_web: got %b%b expected 11", sram_csb, sram_web); end
        nchk++; if (sram_a !== '0 || sram_i !== '0) begin nerr++; $display("FAIL rst_a_i: got a=%h i=%h expected 0", sram_a, sram_i); end
        nchk++; if (sram_oeb !== 1'b0) begin nerr++; $display("FAIL rst_oeb: got %b expected 0", sram_oeb); end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 9'h005; req_wdata[0] = D_A5;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL wr_ready: got %b expected 01", req_ready); end
        nchk++; if (sram_csb !== 1'b0 || sram_web !== 1'b0) begin nerr++; $display("FAIL wr_csb_web: got %b%b expected 00", sram_csb, sram_web); end
        nchk++; if (sram_a !== 9'h005 || sram_i !== D_A5) begin nerr++; $display("FAIL wr_a_i: got a=%h i=%h", sram_a, sram_i); end
        @(negedge clk);
        req_we = 2'b00;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
        nchk++; if (sram_csb !== 1'b0 || sram_web !== 1'b1) begin nerr++; $display("FAIL rd_csb_web: got %b%b expected 01", sram_csb, sram_web); end
        @(negedge clk);
        req_wdata[0] = D_3C;
        #1;
        nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rd_inflight_block: got %b expected 00", req_ready); end
        nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rd_early_valid: got %b expected 00", rsp_valid); end
        nchk++; if (sram_csb !== 1'b1 || sram_web !== 1'b1) begin nerr++; $display("FAIL idle_csb_web: got %b%b expected 11", sram_csb, sram_web); end
        nchk++; if (sram_a !== 9'h005 || sram_i !== D_A5) begin nerr++; $display("FAIL idle_hold: got a=%h i=%h", sram_a, sram_i); end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b01;
        #1;
        nchk++; if (rsp_valid !== 2'b01) begin nerr++; $display("FAIL rd_valid: got %b expected 01", rsp_valid); end
        nchk++; if (rsp_rdata[0] !== D_A5) begin nerr++; $display("FAIL rd_data: got %h expected %h", rsp_rdata[0], D_A5); end
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rd_drained: got %b expected 00", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy;
        @(negedge clk);
        rst = 1'b1; idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11; req_we = 2'b11;
        req_addr[0] = 9'h010; req_addr[1] = 9'h020;
        req_wdata[0] = D_R0;  req_wdata[1] = D_R1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            nchk++; if (req_ready !== exp_rdy) begin nerr++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, exp_rdy); end
            nchk++; if (sram_a !== ((i % 2 == 0) ? 9'h010 : 9'h020)) begin nerr++; $display("FAIL rr_addr[%0d]: got %h", i, sram_a); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 9'h1FF; req_wdata[1] = D_3C;
        #1;
        nchk++; if (req_ready !== 2'b10) begin nerr++; $display("FAIL bp_wr1: got %b expected 10", req_ready); end
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            req_we = 2'b01; req_addr[0] = AW'(9'h030 + c); req_wdata[0] = D_R0;
            rsp_ready = 2'b00;
            if (c == 0)            req_valid = 2'b10;
            else if (c <= 7)       req_valid = 2'b11;
            else                   req_valid = 2'b00;
            if (c == 7 || c == 9)  rsp_ready = 2'b10;
            #1;
            if (c == 0) begin
                nchk++; if (req_ready !== 2'b10) begin nerr++; $display("FAIL bp_rd_grant: got %b expected 10", req_ready); end
            end else if (c <= 6) begin
                nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL bp_w0_grant[%0d]: got %b expected 01", c, req_ready); end
            end else if (c == 7) begin
                nchk++; if (req_ready !== 2'b10) begin nerr++; $display("FAIL bp_reissue: got %b expected 10", req_ready); end
            end
            if (c >= 2 && c <= 7) begin
                nchk++; if (rsp_valid[1] !== 1'b1) begin nerr++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", c, rsp_valid[1]); end
                nchk++; if (rsp_rdata[1] !== D_3C) begin nerr++; $display("FAIL bp_hold_data[%0d]: got %h", c, rsp_rdata[1]); end
            end else if (c == 9) begin
                nchk++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== D_3C) begin nerr++; $display("FAIL bp_second_rsp: got %b %h", rsp_valid[1], rsp_rdata[1]); end
            end else begin
                nchk++; if (rsp_valid[1] !== 1'b0) begin nerr++; $display("FAIL bp_empty[%0d]: got %b expected 0", c, rsp_valid[1]); end
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_drain_reissue();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 9'h007; req_wdata[0] = D_11;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL dr_wr: got %b expected 01", req_ready); end
        @(negedge clk);
        req_we = 2'b00;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL dr_rd: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 9'h007; req_wdata[1] = D_22;
        #1;
        nchk++; if (req_ready !== 2'b10) begin nerr++; $display("FAIL dr_wr1: got %b expected 10", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        nchk++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== D_11) begin nerr++; $display("FAIL dr_old: got %b %h", rsp_valid[0], rsp_rdata[0]); end
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; rsp_ready = 2'b01;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL dr_same_cycle: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00; rsp_ready = 2'b00;
        #1;
        nchk++; if (rsp_valid[0] !== 1'b0) begin nerr++; $display("FAIL dr_gap: got %b expected 0", rsp_valid[0]); end
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        nchk++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== D_22) begin nerr++; $display("FAIL dr_new: got %b %h expected 1 %h", rsp_valid[0], rsp_rdata[0], D_22); end
        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        nchk++; if (rsp_valid[0] !== 1'b0) begin nerr++; $display("FAIL dr_end: got %b expected 0", rsp_valid[0]); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 2'b01; req_we = 2'b00; req_addr[0] = 9'h005;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL rm_rd: got %b expected 01", req_ready); end
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b11; req_we = 2'b11;
        #1;
        nchk++; if (sram_csb !== 1'b1) begin nerr++; $display("FAIL rm_csb: got %b expected 1", sram_csb); end
        nchk++; if (req_ready !== 2'b00) begin nerr++; $display("FAIL rm_ready: got %b expected 00", req_ready); end
        nchk++; if (sram_a !== '0) begin nerr++; $display("FAIL rm_addr: got %h expected 0", sram_a); end
        @(negedge clk);
        rst = 1'b0; req_addr[0] = 9'h040; req_addr[1] = 9'h041;
        #1;
        nchk++; if (req_ready !== 2'b01) begin nerr++; $display("FAIL rm_ptr: got %b expected 01", req_ready); end
        nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rm_rsp0: got %b expected 00", rsp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            nchk++; if (rsp_valid !== 2'b00) begin nerr++; $display("FAIL rm_rsp[%0d]: got %b expected 00", i, rsp_valid); end
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_backpressure();
        test_drain_reissue();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end

endmodule
